// File: rtl/updown_counter_pkg.sv
// Shared mode and direction encodings for the parametrised up/down counter.
package updown_counter_pkg;

    localparam logic [1:0] MODE_WRAP   = 2'b00;
    localparam logic [1:0] MODE_SAT    = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/counter_next_calc.sv
// Next-count arithmetic: boundary detection plus wrap/saturate/bounce resolution.
// Purely combinational; all math is done one bit wider than the count so nothing overflows.
module counter_next_calc
    import updown_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 2**WIDTH-1,
    parameter int STEP    = 1
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic             d_i,
    input  logic [1:0]       mode_i,
    output logic [WIDTH-1:0] q_next_o,
    output logic             boundary_o,
    output logic             dir_next_o
);

    localparam int XW = WIDTH + 1;
    localparam logic [XW-1:0] MIN_X   = XW'(MIN_VAL);
    localparam logic [XW-1:0] MAX_X   = XW'(MAX_VAL);
    localparam logic [XW-1:0] STEP_X  = XW'(STEP);
    localparam logic [XW-1:0] RANGE_X = XW'(MAX_VAL - MIN_VAL + 1);

    logic [XW-1:0] q_x;
    logic [XW-1:0] up_sum;
    logic [XW-1:0] dn_diff;
    logic [XW-1:0] next_x;

    always_comb begin
        q_x        = {1'b0, q_i};
        up_sum     = q_x + STEP_X;
        dn_diff    = q_x - STEP_X;
        boundary_o = (d_i == DIR_UP) ? (up_sum > MAX_X) : (q_x < MIN_X + STEP_X);
        next_x     = (d_i == DIR_UP) ? up_sum : dn_diff;
        dir_next_o = d_i;

        if (boundary_o) begin
            unique case (mode_i)
                MODE_SAT: begin
                    next_x = (d_i == DIR_UP) ? MAX_X : MIN_X;
                end
                MODE_BOUNCE: begin
                    // Reflect the overshoot back off the bound and turn around.
                    next_x     = (d_i == DIR_UP) ? (MAX_X + MAX_X - up_sum)
                                                 : (MIN_X + MIN_X + STEP_X - q_x);
                    dir_next_o = ~d_i;
                end
                default: begin
                    next_x = (d_i == DIR_UP) ? (up_sum - RANGE_X)
                                             : (q_x + RANGE_X - STEP_X);
                end
            endcase
        end

        q_next_o = WIDTH'(next_x);
    end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with load, wrap/saturate/bounce modes and a registered tc pulse.
// Registers and priority (reset > load > pause > count) live here; arithmetic is in counter_next_calc.
module updown_counter_param
    import updown_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 2**WIDTH-1,
    parameter int STEP    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pause,
    input  logic             UP_DOWN,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] Q,
    output logic             dir,
    output logic             tc,
    output logic             at_max,
    output logic             at_min
);

    if (!(MIN_VAL >= 0 && MIN_VAL < MAX_VAL && MAX_VAL <= 2**WIDTH-1)) begin : g_bad_bounds
        $error("updown_counter_param: need 0 <= MIN_VAL < MAX_VAL <= 2**WIDTH-1");
    end
    if (!(STEP >= 1 && STEP <= MAX_VAL - MIN_VAL)) begin : g_bad_step
        $error("updown_counter_param: need 1 <= STEP <= MAX_VAL-MIN_VAL");
    end

    localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] q_q, q_d;
    logic             dir_q, dir_d;
    logic             tc_q, tc_d;

    logic             cnt_dir;
    logic [WIDTH-1:0] calc_q;
    logic             calc_boundary;
    logic             calc_dir;
    logic [WIDTH-1:0] load_clamped;

    // BOUNCE follows its own stored direction; the other modes obey UP_DOWN.
    assign cnt_dir = (mode == MODE_BOUNCE) ? dir_q : UP_DOWN;

    counter_next_calc #(
        .WIDTH   (WIDTH),
        .MIN_VAL (MIN_VAL),
        .MAX_VAL (MAX_VAL),
        .STEP    (STEP)
    ) u_next_calc (
        .q_i        (q_q),
        .d_i        (cnt_dir),
        .mode_i     (mode),
        .q_next_o   (calc_q),
        .boundary_o (calc_boundary),
        .dir_next_o (calc_dir)
    );

    always_comb begin
        load_clamped = load_val;
        if (load_val < MIN_W) begin
            load_clamped = MIN_W;
        end else if (load_val > MAX_W) begin
            load_clamped = MAX_W;
        end
    end

    always_comb begin
        q_d   = q_q;
        dir_d = dir_q;
        tc_d  = 1'b0;
        if (load) begin
            q_d   = load_clamped;
            dir_d = UP_DOWN;
        end else if (!pause) begin
            q_d   = calc_q;
            dir_d = calc_dir;
            tc_d  = calc_boundary;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q   <= MIN_W;
            dir_q <= DIR_UP;
            tc_q  <= 1'b0;
        end else begin
            q_q   <= q_d;
            dir_q <= dir_d;
            tc_q  <= tc_d;
        end
    end

    assign Q      = q_q;
    assign dir    = dir_q;
    assign tc     = tc_q;
    assign at_max = (q_q == MAX_W);
    assign at_min = (q_q == MIN_W);

endmodule

// File: tb/tb_updown_counter_param.sv
// Two counter instances (0..9 step 1, 2..13 step 3) driven by directed steps then random traffic,
// each compared every cycle against an integer reference model.
module tb_updown_counter_param;

    localparam int AMIN = 0, AMAX = 9,  ASTEP = 1;
    localparam int BMIN = 2, BMAX = 13, BSTEP = 3;

    logic       clk = 1'b0;
    logic       a_reset, a_pause, a_ud, a_load;
    logic [3:0] a_lv;
    logic [1:0] a_mode;
    logic [3:0] a_q;
    logic       a_dir, a_tc, a_amax, a_amin;
    logic       b_reset, b_pause, b_ud, b_load;
    logic [3:0] b_lv;
    logic [1:0] b_mode;
    logic [3:0] b_q;
    logic       b_dir, b_tc, b_amax, b_amin;

    int n_checks = 0;
    int n_errors = 0;
    int a_mq = AMIN, b_mq = BMIN;
    bit a_mdir = 1'b1, a_mtc = 1'b0, b_mdir = 1'b1, b_mtc = 1'b0;

    always #5 clk = ~clk;

    updown_counter_param #(.WIDTH(4), .MIN_VAL(AMIN), .MAX_VAL(AMAX), .STEP(ASTEP)) dut_a (
        .clk(clk), .reset(a_reset), .pause(a_pause), .UP_DOWN(a_ud), .load(a_load),
        .load_val(a_lv), .mode(a_mode), .Q(a_q), .dir(a_dir), .tc(a_tc),
        .at_max(a_amax), .at_min(a_amin)
    );

    updown_counter_param #(.WIDTH(4), .MIN_VAL(BMIN), .MAX_VAL(BMAX), .STEP(BSTEP)) dut_b (
        .clk(clk), .reset(b_reset), .pause(b_pause), .UP_DOWN(b_ud), .load(b_load),
        .load_val(b_lv), .mode(b_mode), .Q(b_q), .dir(b_dir), .tc(b_tc),
        .at_max(b_amax), .at_min(b_amin)
    );

    // Reference: plain signed integer arithmetic, modulo for wrap, mirror for bounce.
    function automatic void ref_step(input int mn, input int mx, input int st,
                                     input bit rst, input bit ld, input bit ps, input bit ud,
                                     input int lv, input int md,
                                     inout int q, inout bit dr, inout bit t);
        int  n;
        int  r;
        bit  up;
        bit  hit;
        if (rst) begin
            q = mn; dr = 1'b1; t = 1'b0;
        end else if (ld) begin
            q  = (lv < mn) ? mn : ((lv > mx) ? mx : lv);
            dr = ud;
            t  = 1'b0;
        end else if (ps) begin
            t = 1'b0;
        end else begin
            up  = (md == 2) ? dr : ud;
            r   = mx - mn + 1;
            n   = up ? q + st : q - st;
            hit = up ? (n > mx) : (n < mn);
            if (md == 1) begin
                if (hit) n = up ? mx : mn;
                dr = ud;
            end else if (md == 2) begin
                if (hit) begin
                    n  = up ? 2*mx - n : 2*mn - n;
                    dr = !up;
                end
            end else begin
                n  = mn + ((((n - mn) % r) + r) % r);
                dr = ud;
            end
            q = n;
            t = hit;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        ref_step(AMIN, AMAX, ASTEP, a_reset, a_load, a_pause, a_ud, int'(a_lv), int'(a_mode),
                 a_mq, a_mdir, a_mtc);
        ref_step(BMIN, BMAX, BSTEP, b_reset, b_load, b_pause, b_ud, int'(b_lv), int'(b_mode),
                 b_mq, b_mdir, b_mtc);
        #1;
        check("A.Q",      32'(a_q),    32'(a_mq));
        check("A.dir",    32'(a_dir),  32'(a_mdir));
        check("A.tc",     32'(a_tc),   32'(a_mtc));
        check("A.at_max", 32'(a_amax), 32'(a_mq == AMAX));
        check("A.at_min", 32'(a_amin), 32'(a_mq == AMIN));
        check("B.Q",      32'(b_q),    32'(b_mq));
        check("B.dir",    32'(b_dir),  32'(b_mdir));
        check("B.tc",     32'(b_tc),   32'(b_mtc));
        check("B.at_max", 32'(b_amax), 32'(b_mq == BMAX));
        check("B.at_min", 32'(b_amin), 32'(b_mq == BMIN));
    endtask

    initial begin
        a_reset = 1; a_pause = 0; a_ud = 1; a_load = 0; a_lv = 0; a_mode = 2'b00;
        b_reset = 1; b_pause = 0; b_ud = 1; b_load = 0; b_lv = 0; b_mode = 2'b00;

        // Reset state
        tick();
        check("rst.Q", 32'(a_q), 0);
        check("rst.dir", 32'(a_dir), 1);
        check("rst.tc", 32'(a_tc), 0);

        // WRAP up over 0..9
        a_reset = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            check("wrap.Q", 32'(a_q), 32'(i % 10));
            check("wrap.tc", 32'(a_tc), 32'(i % 10 == 0));
            check("wrap.at_max", 32'(a_amax), 32'(i % 10 == 9));
        end

        // SAT down pinned at MIN
        a_reset = 1; a_mode = 2'b01; a_ud = 0;
        tick();
        a_reset = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sat.Q", 32'(a_q), 0);
            check("sat.tc", 32'(a_tc), 1);
            check("sat.at_min", 32'(a_amin), 1);
        end

        // BOUNCE off MAX from a load of 8
        a_mode = 2'b10; a_load = 1; a_lv = 4'd8; a_ud = 1;
        tick();
        a_load = 0; a_ud = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bounce.Q", 32'(a_q), 32'((i == 0) ? 9 : 9 - i));
            check("bounce.dir", 32'(a_dir), 32'(i == 0));
            check("bounce.tc", 32'(a_tc), 32'(i == 1));
        end

        // Load clamp and priorities
        a_load = 1; a_lv = 4'd14; a_ud = 1;
        tick();
        check("load.clamp", 32'(a_q), 9);
        a_pause = 1; a_lv = 4'd3;
        tick();
        check("load.over_pause", 32'(a_q), 3);
        a_pause = 0; a_reset = 1; a_lv = 4'd5;
        tick();
        check("rst.over_load.Q", 32'(a_q), 0);
        check("rst.over_load.dir", 32'(a_dir), 1);
        check("rst.over_load.tc", 32'(a_tc), 0);

        // Pause mid-count at 4
        a_reset = 0; a_load = 0; a_mode = 2'b00; a_ud = 1;
        repeat (4) tick();
        check("pre_pause.Q", 32'(a_q), 4);
        a_pause = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("pause.Q", 32'(a_q), 4);
            check("pause.tc", 32'(a_tc), 0);
        end
        a_pause = 0;
        tick();
        check("resume.Q", 32'(a_q), 5);

        // Instance B: STEP 3 wrap across both bounds
        a_pause = 1;
        b_reset = 0; b_load = 1; b_lv = 4'd12; b_ud = 1; b_mode = 2'b00;
        tick();
        b_load = 0;
        tick();
        check("b.wrap_up.Q", 32'(b_q), 3);
        check("b.wrap_up.tc", 32'(b_tc), 1);
        b_ud = 0;
        tick();
        check("b.wrap_dn.Q", 32'(b_q), 12);
        check("b.wrap_dn.tc", 32'(b_tc), 1);

        // Random traffic on both instances
        for (int i = 0; i < 600; i++) begin
            a_reset = ($urandom_range(31) == 0);
            a_load  = ($urandom_range(7) == 0);
            a_pause = ($urandom_range(5) == 0);
            a_ud    = 1'($urandom_range(1));
            a_mode  = 2'($urandom_range(3));
            a_lv    = 4'($urandom_range(15));
            b_reset = ($urandom_range(31) == 0);
            b_load  = ($urandom_range(7) == 0);
            b_pause = ($urandom_range(5) == 0);
            b_ud    = 1'($urandom_range(1));
            b_mode  = 2'($urandom_range(3));
            b_lv    = 4'($urandom_range(15));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
